// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry owner-tagged response buffer. Optional counters: ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_op_a,
  input  logic [DATA_W-1:0] i_req0_op_b,
  input  logic [OP_W-1:0]   i_req0_alu_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_op_a,
  input  logic [DATA_W-1:0] i_req1_op_b,
  input  logic [OP_W-1:0]   i_req1_alu_op,
  output logic [DATA_W-1:0] o_alu_op_a,
  output logic [DATA_W-1:0] o_alu_op_b,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp1_data,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0]  o_cnt0,
  output logic [CNT_W-1:0]  o_cnt1,
`endif
  output logic              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Request ready may depend combinationally on valid; responses hold until taken.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              owner_ready;
  logic              can_accept;
  logic              grant_vld;
  logic              grant_id;
  logic              drain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    result_d    = result_q;
    grant_vld   = 1'b0;
    grant_id    = 1'b0;
    owner_ready = owner_q ? i_rsp1_ready : i_rsp0_ready;
    drain       = (state_q == FULL) && owner_ready;
    can_accept  = (state_q == EMPTY) || owner_ready;

    if (can_accept) begin
      if (i_req0_valid && i_req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_q;
      end else if (i_req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (i_req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end

    if (grant_vld) begin
      state_d  = FULL;
      owner_d  = grant_id;
      last_d   = grant_id;
      result_d = i_alu_data;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  assign o_req0_ready = grant_vld && !grant_id;
  assign o_req1_ready = grant_vld && grant_id;

  // Idle ALU inputs are parked at zero/ADD so the ALU does not toggle.
  always_comb begin
    o_alu_op_a = '0;
    o_alu_op_b = '0;
    o_alu_op   = '0;
    if (grant_vld) begin
      o_alu_op_a = grant_id ? i_req1_op_a   : i_req0_op_a;
      o_alu_op_b = grant_id ? i_req1_op_b   : i_req0_op_b;
      o_alu_op   = grant_id ? i_req1_alu_op : i_req0_alu_op;
    end
  end

  assign o_rsp0_valid = (state_q == FULL) && !owner_q;
  assign o_rsp1_valid = (state_q == FULL) && owner_q;
  assign o_rsp0_data  = o_rsp0_valid ? result_q : '0;
  assign o_rsp1_data  = o_rsp1_valid ? result_q : '0;
  assign o_dbg_state  = state_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (o_req0_ready && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (o_req1_ready && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign o_cnt0 = cnt0_q;
  assign o_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0, v1, rdy0, rdy1, rr0, rr1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [3:0]    op0, op1;
  logic [W-1:0]  alu_a, alu_b, alu_data;
  logic [3:0]    alu_op;
  logic          rv0, rv1;
  logic [W-1:0]  rd0, rd1;
  logic          dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [3:0]    cnt0, cnt1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
`ifdef ALU_ARB_STATS_EN
    .CNT_W(4)
`else
    .CNT_W(16)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0),
    .i_req0_op_a(a0), .i_req0_op_b(b0), .i_req0_alu_op(op0),
    .i_req1_valid(v1), .o_req1_ready(rdy1),
    .i_req1_op_a(a1), .i_req1_op_b(b1), .i_req1_alu_op(op1),
    .o_alu_op_a(alu_a), .o_alu_op_b(alu_b), .o_alu_op(alu_op),
    .i_alu_data(alu_data),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_data(rd0),
    .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_data(rd1),
`ifdef ALU_ARB_STATS_EN
    .o_cnt0(cnt0), .o_cnt1(cnt1),
`endif
    .o_dbg_state(dbg_state)
  );

  // Stand-in ALU; unused encodings return an arbitrary but known mix.
  function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      default: return (a ^ {b[15:0], b[31:16]}) + {28'h0, op};
    endcase
  endfunction

  always_comb alu_data = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    rr0 = 1; rr1 = 1;
  endtask

  // Ends at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 0;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst;
    logic v0; logic [W-1:0] a0, b0; logic [3:0] op0;
    logic v1; logic [W-1:0] a1, b1; logic [3:0] op1;
    logic rr0, rr1;
    logic e_rdy0, e_rdy1;
    logic e_v0; logic [W-1:0] e_d0;
    logic e_v1; logic [W-1:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst,
      logic iv0, logic [W-1:0] ia0, logic [W-1:0] ib0, logic [3:0] iop0,
      logic iv1, logic [W-1:0] ia1, logic [W-1:0] ib1, logic [3:0] iop1,
      logic irr0, logic irr1, logic er0, logic er1,
      logic ev0, logic [W-1:0] ed0, logic ev1, logic [W-1:0] ed1);
    vec_t t;
    t.rst = rst; t.v0 = iv0; t.a0 = ia0; t.b0 = ib0; t.op0 = iop0;
    t.v1 = iv1; t.a1 = ia1; t.b1 = ib1; t.op1 = iop1;
    t.rr0 = irr0; t.rr1 = irr1; t.e_rdy0 = er0; t.e_rdy1 = er1;
    t.e_v0 = ev0; t.e_d0 = ed0; t.e_v1 = ev1; t.e_d1 = ed1;
    return t;
  endfunction

  task automatic run_table();
    logic [W-1:0] ea, eb;
    logic [3:0]   eo;
    // single op: 5+3
    vecs.push_back(mk(1, 1,5,3,0,     0,0,0,0,       1,1, 1,0, 0,0,    0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 1,8,    0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 0,0,    0,0));
    // tie after reset: req0 SUB first, req1 XOR next
    vecs.push_back(mk(1, 1,10,4,1,    1,'hF0,'h0F,4, 1,1, 1,0, 0,0,    0,0));
    vecs.push_back(mk(0, 0,0,0,0,     1,'hF0,'h0F,4, 1,1, 0,1, 1,6,    0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 0,0,    1,'hFF));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 0,0,    0,0));
    // backpressure: req1 result 0x12 held for 5 cycles blocks req0
    vecs.push_back(mk(0, 0,0,0,0,     1,'h10,2,0,    1,0, 0,1, 0,0,    0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1,1,1,0,   0,0,0,0,       1,0, 0,0, 0,0,    1,'h12));
    vecs.push_back(mk(0, 1,1,1,0,     0,0,0,0,       1,1, 1,0, 0,0,    1,'h12));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 1,2,    0,0));
    // unused opcode forwarded unchanged; stray rsp1_ready ignored
    vecs.push_back(mk(0, 1,7,9,'hA,   0,0,0,0,       0,1, 1,0, 0,0,    0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       0,1, 0,0, 1,alu_f(7,9,'hA), 0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 1,alu_f(7,9,'hA), 0,0));
    vecs.push_back(mk(0, 0,0,0,0,     0,0,0,0,       1,1, 0,0, 0,0,    0,0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        @(negedge clk);
        chk("reset_rsp0_valid", rv0, 0);
        chk("reset_rsp1_valid", rv1, 0);
        chk("reset_rsp0_data", rd0, 0);
        chk("reset_alu_a", alu_a, 0);
        next_cycle();
      end
      v0 = vecs[i].v0; a0 = vecs[i].a0; b0 = vecs[i].b0; op0 = vecs[i].op0;
      v1 = vecs[i].v1; a1 = vecs[i].a1; b1 = vecs[i].b1; op1 = vecs[i].op1;
      rr0 = vecs[i].rr0; rr1 = vecs[i].rr1;
      @(negedge clk);
      chk($sformatf("vec%0d_ready0", i), rdy0, vecs[i].e_rdy0);
      chk($sformatf("vec%0d_ready1", i), rdy1, vecs[i].e_rdy1);
      chk($sformatf("vec%0d_rsp0_valid", i), rv0, vecs[i].e_v0);
      chk($sformatf("vec%0d_rsp0_data", i), rd0, vecs[i].e_d0);
      chk($sformatf("vec%0d_rsp1_valid", i), rv1, vecs[i].e_v1);
      chk($sformatf("vec%0d_rsp1_data", i), rd1, vecs[i].e_d1);
      ea = vecs[i].e_rdy0 ? vecs[i].a0  : vecs[i].e_rdy1 ? vecs[i].a1  : '0;
      eb = vecs[i].e_rdy0 ? vecs[i].b0  : vecs[i].e_rdy1 ? vecs[i].b1  : '0;
      eo = vecs[i].e_rdy0 ? vecs[i].op0 : vecs[i].e_rdy1 ? vecs[i].op1 : '0;
      chk($sformatf("vec%0d_alu_a", i), alu_a, ea);
      chk($sformatf("vec%0d_alu_b", i), alu_b, eb);
      chk($sformatf("vec%0d_alu_op", i), {28'h0, alu_op}, {28'h0, eo});
      next_cycle();
    end
  endtask

  // ---------------- streaming: strict alternation ----------------
  task automatic run_stream();
    int n0 = 0, n1 = 0, got = 0;
    logic last_owner;
    logic [W-1:0] held;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      v0 = (c < 8); a0 = 100 + n0; b0 = 1; op0 = 0;
      v1 = (c < 8); a1 = 200 + n1; b1 = 2; op1 = 1;
      @(negedge clk);
      if (c < 8) begin
        chk($sformatf("stream%0d_ready0", c), rdy0, (c % 2) == 0);
        chk($sformatf("stream%0d_ready1", c), rdy1, (c % 2) == 1);
      end
      if (c > 0) begin
        chk($sformatf("stream%0d_rsp_valid", c), last_owner ? rv1 : rv0, 1);
        chk($sformatf("stream%0d_rsp_data", c), last_owner ? rd1 : rd0, held);
        if ((last_owner ? rv1 : rv0) === 1'b1) got++;
      end
      if (c < 8) begin
        last_owner = (c % 2 == 1);
        held = last_owner ? (200 + n1 - 2) : (100 + n0 + 1);
        if (last_owner) n1++; else n0++;
      end
      next_cycle();
    end
    chk("stream_result_count", got, 8);
    idle();
  endtask

  // ---------------- reset while FULL with owner 1 ----------------
  task automatic run_reset_mid();
    do_reset();
    v1 = 1; a1 = 3; b1 = 4; op1 = 0; rr1 = 0;
    @(negedge clk);
    chk("rstmid_ready1", rdy1, 1);
    next_cycle();
    v1 = 0;
    @(negedge clk);
    chk("rstmid_rsp1_held", rv1, 1);
    chk("rstmid_rsp1_data", rd1, 7);
    #1 rst_n = 0;
    #1;
    chk("rstmid_rsp1_async_drop", rv1, 0);
    chk("rstmid_rsp1_data_clear", rd1, 0);
    @(posedge clk);
    #1 rst_n = 1;
    idle();
    v0 = 1; a0 = 1; v1 = 1; a1 = 2;
    @(negedge clk);
    chk("rstmid_req0_first", rdy0, 1);
    chk("rstmid_req1_wait", rdy1, 0);
    next_cycle();
    idle();
    next_cycle();
  endtask

  // ---------------- randomized traffic vs reference model ----------------
  typedef struct { logic [W-1:0] a, b; logic [3:0] op; } op_t;

  task automatic run_random(input int cycles);
    op_t pend0[$], pend1[$];
    logic [W-1:0] exp_q0[$], exp_q1[$];
    logic m_full = 0, m_owner = 0, m_last = 1;
    logic can, gv, g, own_rdy;
    op_t o, gop;
    do_reset();
    for (int c = 0; c < cycles + 12; c++) begin
      if (c < cycles && $urandom_range(0, 99) < 60) begin
        o.a = $urandom; o.b = $urandom; o.op = 4'($urandom_range(0, 15));
        if (pend0.size() < 3) pend0.push_back(o);
      end
      if (c < cycles && $urandom_range(0, 99) < 60) begin
        o.a = $urandom; o.b = $urandom; o.op = 4'($urandom_range(0, 15));
        if (pend1.size() < 3) pend1.push_back(o);
      end
      v0 = pend0.size() > 0; v1 = pend1.size() > 0;
      if (v0) begin a0 = pend0[0].a; b0 = pend0[0].b; op0 = pend0[0].op; end
      else begin a0 = 0; b0 = 0; op0 = 0; end
      if (v1) begin a1 = pend1[0].a; b1 = pend1[0].b; op1 = pend1[0].op; end
      else begin a1 = 0; b1 = 0; op1 = 0; end
      rr0 = (c >= cycles) || ($urandom_range(0, 99) < 70);
      rr1 = (c >= cycles) || ($urandom_range(0, 99) < 70);

      // Model: single buffer, refill allowed when its owner is draining,
      // ties go to whoever did not win last.
      own_rdy = m_owner ? rr1 : rr0;
      can = !m_full || own_rdy;
      gv = can && (v0 || v1);
      g = (v0 && v1) ? !m_last : v1;
      gop.a = 0; gop.b = 0; gop.op = 0;
      if (gv) gop = g ? pend1[0] : pend0[0];

      @(negedge clk);
      chk("rand_ready0", rdy0, gv && !g);
      chk("rand_ready1", rdy1, gv && g);
      chk("rand_alu_a", alu_a, gop.a);
      chk("rand_alu_op", {28'h0, alu_op}, {28'h0, gop.op});
      chk("rand_rsp0_valid", rv0, m_full && !m_owner);
      chk("rand_rsp1_valid", rv1, m_full && m_owner);
      if (m_full && !m_owner) chk("rand_rsp0_data", rd0, exp_q0[0]);
      if (m_full && m_owner)  chk("rand_rsp1_data", rd1, exp_q1[0]);

      if (m_full && own_rdy) begin
        if (m_owner) void'(exp_q1.pop_front()); else void'(exp_q0.pop_front());
        m_full = 0;
      end
      if (gv) begin
        if (g) begin exp_q1.push_back(alu_f(gop.a, gop.b, gop.op)); void'(pend1.pop_front()); end
        else   begin exp_q0.push_back(alu_f(gop.a, gop.b, gop.op)); void'(pend0.pop_front()); end
        m_full = 1; m_owner = g; m_last = g;
      end
      next_cycle();
    end
    chk("rand_drained_req0", pend0.size(), 0);
    chk("rand_drained_req1", pend1.size(), 0);
    chk("rand_buffer_empty", rv0 | rv1, 0);
    idle();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic run_stats();
    do_reset();
    chk("stats_reset_cnt0", cnt0, 0);
    for (int i = 0; i < 17; i++) begin
      v0 = 1; a0 = i; b0 = 1; op0 = 0;
      next_cycle();
    end
    idle();
    next_cycle();
    chk("stats_cnt0_saturated", cnt0, 15);
    chk("stats_cnt1_zero", cnt1, 0);
  endtask
`endif

  initial begin
    idle();
    run_table();
    run_stream();
    run_reset_mid();
    run_random(400);
`ifdef ALU_ARB_STATS_EN
    run_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
